// File: rtl/sprite_anim_render.sv
// Sprite renderer: walks a frame-ROM pixel address across the sprite window and
// sequences DEAD/ALIVE/DYING animation frames; pixel out one cycle after request.
module sprite_anim_render #(
  parameter int H_BITS         = 10,
  parameter int V_BITS         = 10,
  parameter int X_SIZE         = 32,
  parameter int Y_SIZE         = 32,
  parameter int GRAY_BITS      = 4,
  parameter int NUM_FRAMES     = 2,
  parameter int DESTROY_FRAMES = 3,
  parameter int FRAME_HOLD     = 8,
  localparam int PIX = X_SIZE * Y_SIZE,
  localparam int AW  = (PIX > 1) ? $clog2(PIX) : 1,
  localparam int FW  = $clog2(NUM_FRAMES + DESTROY_FRAMES)
) (
  input  logic                   clk_vga,
  input  logic                   rst,
  input  logic                   v_sync_i,
  input  logic [H_BITS-1:0]      req_x_addr_i,
  input  logic [V_BITS-1:0]      req_y_addr_i,
  input  logic [H_BITS-1:0]      x_pos_i,
  input  logic [V_BITS-1:0]      y_pos_i,
  input  logic                   spawn_i,
  input  logic                   destroy_i,
  output logic                   rom_en_o,
  output logic [AW-1:0]          rom_addr_o,
  output logic [FW-1:0]          rom_frame_o,
  input  logic [GRAY_BITS:0]     rom_data_i,
  output logic [3*GRAY_BITS-1:0] vga_rgb_o,
  output logic                   vga_alpha_o,
  output logic                   alive_o,
  output logic                   done_o
);

  localparam int MAXF = (NUM_FRAMES > DESTROY_FRAMES) ? NUM_FRAMES : DESTROY_FRAMES;
  localparam int IW   = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam int HW   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  localparam logic [IW-1:0]   NUM_LAST  = IW'(NUM_FRAMES - 1);
  localparam logic [IW-1:0]   DES_LAST  = IW'(DESTROY_FRAMES - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(FRAME_HOLD - 1);
  localparam logic [AW-1:0]   PIX_LAST  = AW'(PIX - 1);
  localparam logic [H_BITS:0] X_EXT     = (H_BITS+1)'(X_SIZE);
  localparam logic [V_BITS:0] Y_EXT     = (V_BITS+1)'(Y_SIZE);

  typedef enum logic [1:0] {DEAD, ALIVE, DYING} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     img_idx, img_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic              done_n;
  logic [AW-1:0]     pix_cnt;
  logic [H_BITS-1:0] x_lat;
  logic [V_BITS-1:0] y_lat;
  logic              vs_q, vs_qq, frame_tick;
  logic              in_area, vis_d, hold_exp;
  logic [H_BITS:0]   x_end;
  logic [V_BITS:0]   y_end;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
    end else begin
      vs_q  <= v_sync_i;
      vs_qq <= vs_q;
    end
  end

  assign frame_tick = vs_qq & ~vs_q;

  // One extra bit on the window end so a sprite at the screen edge never wraps.
  assign x_end = {1'b0, x_lat} + X_EXT;
  assign y_end = {1'b0, y_lat} + Y_EXT;

  assign in_area = (state != DEAD) &&
                   (req_x_addr_i >= x_lat) && ({1'b0, req_x_addr_i} < x_end) &&
                   (req_y_addr_i >= y_lat) && ({1'b0, req_y_addr_i} < y_end);

  assign rom_en_o   = in_area;
  assign rom_addr_o = pix_cnt;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      x_lat   <= '0;
      y_lat   <= '0;
      pix_cnt <= '0;
      vis_d   <= 1'b0;
    end else begin
      vis_d <= in_area;
      if (frame_tick) begin
        x_lat   <= x_pos_i;
        y_lat   <= y_pos_i;
        pix_cnt <= '0;
      end else if (in_area && (pix_cnt != PIX_LAST)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  assign vga_alpha_o = vis_d & rom_data_i[GRAY_BITS];
  assign vga_rgb_o   = vis_d ? {3{rom_data_i[GRAY_BITS-1:0]}} : '0;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state    <= DEAD;
      img_idx  <= '0;
      hold_cnt <= '0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_n;
      img_idx  <= img_n;
      hold_cnt <= hold_n;
      done_o   <= done_n;
    end
  end

  assign hold_exp = frame_tick && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_n = state;
    img_n   = img_idx;
    hold_n  = hold_cnt;
    done_n  = 1'b0;
    case (state)
      DEAD: begin
        if (spawn_i) begin
          state_n = ALIVE;
          img_n   = '0;
          hold_n  = '0;
        end
      end
      ALIVE: begin
        // destroy outranks both spawn and the frame tick
        if (destroy_i) begin
          state_n = DYING;
          img_n   = '0;
          hold_n  = '0;
        end else if (hold_exp) begin
          hold_n = '0;
          img_n  = (img_idx == NUM_LAST) ? '0 : img_idx + 1'b1;
        end else if (frame_tick) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      DYING: begin
        if (hold_exp) begin
          hold_n = '0;
          if (img_idx == DES_LAST) begin
            state_n = DEAD;
            img_n   = '0;
            done_n  = 1'b1;
          end else begin
            img_n = img_idx + 1'b1;
          end
        end else if (frame_tick) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = DEAD;
        img_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_comb begin
    alive_o     = 1'b0;
    rom_frame_o = '0;
    case (state)
      ALIVE: begin
        alive_o     = 1'b1;
        rom_frame_o = FW'(img_idx);
      end
      DYING: rom_frame_o = FW'(NUM_FRAMES) + FW'(img_idx);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sprite_anim_render.sv
// Directed bench for sprite_anim_render with a small registered frame-ROM model.
module tb_sprite_anim_render;

  logic        clk_vga = 1'b0;
  logic        rst = 1'b1;
  logic        v_sync = 1'b1;
  logic [9:0]  req_x, req_y, x_pos, y_pos;
  logic        spawn = 1'b0, destroy = 1'b0;
  logic        rom_en;
  logic [3:0]  rom_addr;
  logic [2:0]  rom_frame;
  logic [4:0]  rom_data;
  logic [11:0] rgb;
  logic        alpha, alive, done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  logic [9:0] idle_x = 10'd500, idle_y = 10'd500;
  logic       pend_vld = 1'b0, pend_en = 1'b0;
  logic [3:0] pend_addr = '0;
  logic [2:0] pend_frame = '0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic [3:0] addr;
  } vec_t;

  vec_t main_tbl[18];
  vec_t edge_tbl[8];
  logic [2:0] alive_before[6];
  logic [2:0] alive_after[6];
  logic [2:0] dying_before[6];

  always #5 clk_vga = ~clk_vga;

  sprite_anim_render #(
    .H_BITS(10), .V_BITS(10), .X_SIZE(4), .Y_SIZE(3), .GRAY_BITS(4),
    .NUM_FRAMES(2), .DESTROY_FRAMES(3), .FRAME_HOLD(2)
  ) dut (
    .clk_vga(clk_vga), .rst(rst), .v_sync_i(v_sync),
    .req_x_addr_i(req_x), .req_y_addr_i(req_y),
    .x_pos_i(x_pos), .y_pos_i(y_pos),
    .spawn_i(spawn), .destroy_i(destroy),
    .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_frame_o(rom_frame),
    .rom_data_i(rom_data), .vga_rgb_o(rgb), .vga_alpha_o(alpha),
    .alive_o(alive), .done_o(done)
  );

  function automatic logic [4:0] romval(input logic [2:0] f, input logic [3:0] a);
    logic [3:0] g;
    g = 4'(a * 3 + f * 5);
    return {a[0] ^ f[0], g};
  endfunction

  always @(posedge clk_vga) rom_data <= romval(rom_frame, rom_addr);
  always @(negedge clk_vga) if (done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One request cycle; also checks the pixel returned for the previous request.
  task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic c,
                     input logic e, input logic [3:0] a, input logic [2:0] f);
    logic [4:0] d;
    @(posedge clk_vga); #1;
    req_x = x; req_y = y;
    @(negedge clk_vga);
    if (pend_vld) begin
      d = romval(pend_frame, pend_addr);
      check("rgb", rgb, pend_en ? {3{d[3:0]}} : 12'h0);
      check("alpha", alpha, pend_en & d[4]);
    end
    if (c) begin
      check("rom_en", rom_en, e);
      if (e) check("rom_addr", rom_addr, a);
      check("rom_frame", rom_frame, f);
    end
    pend_vld = c; pend_en = e; pend_addr = a; pend_frame = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(idle_x, idle_y, 1'b0, 1'b0, 4'd0, 3'd0);
  endtask

  task automatic pulse(input logic sp, input logic de);
    @(posedge clk_vga); #1;
    spawn = sp; destroy = de;
    @(posedge clk_vga); #1;
    spawn = 1'b0; destroy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_vga); #1;
    v_sync = 1'b0;
    repeat (2) @(posedge clk_vga);
    #1 v_sync = 1'b1;
    repeat (2) @(posedge clk_vga);
    #1;
  endtask

  initial begin
    main_tbl[0]  = '{10'd9,  10'd5, 1'b0, 4'd0};
    main_tbl[1]  = '{10'd10, 10'd5, 1'b1, 4'd0};
    main_tbl[2]  = '{10'd11, 10'd5, 1'b1, 4'd1};
    main_tbl[3]  = '{10'd12, 10'd5, 1'b1, 4'd2};
    main_tbl[4]  = '{10'd13, 10'd5, 1'b1, 4'd3};
    main_tbl[5]  = '{10'd14, 10'd5, 1'b0, 4'd0};
    main_tbl[6]  = '{10'd10, 10'd4, 1'b0, 4'd0};
    main_tbl[7]  = '{10'd10, 10'd6, 1'b1, 4'd4};
    main_tbl[8]  = '{10'd11, 10'd6, 1'b1, 4'd5};
    main_tbl[9]  = '{10'd12, 10'd6, 1'b1, 4'd6};
    main_tbl[10] = '{10'd13, 10'd6, 1'b1, 4'd7};
    main_tbl[11] = '{10'd10, 10'd7, 1'b1, 4'd8};
    main_tbl[12] = '{10'd11, 10'd7, 1'b1, 4'd9};
    main_tbl[13] = '{10'd12, 10'd7, 1'b1, 4'd10};
    main_tbl[14] = '{10'd13, 10'd7, 1'b1, 4'd11};
    main_tbl[15] = '{10'd10, 10'd8, 1'b0, 4'd0};
    main_tbl[16] = '{10'd10, 10'd5, 1'b1, 4'd11};
    main_tbl[17] = '{10'd13, 10'd7, 1'b1, 4'd11};

    edge_tbl[0] = '{10'd1020, 10'd1023, 1'b0, 4'd0};
    edge_tbl[1] = '{10'd1021, 10'd1023, 1'b0, 4'd0};
    edge_tbl[2] = '{10'd1022, 10'd1023, 1'b1, 4'd0};
    edge_tbl[3] = '{10'd1023, 10'd1023, 1'b1, 4'd1};
    edge_tbl[4] = '{10'd1022, 10'd1022, 1'b0, 4'd0};
    edge_tbl[5] = '{10'd1023, 10'd1022, 1'b0, 4'd0};
    edge_tbl[6] = '{10'd0,    10'd0,    1'b0, 4'd0};
    edge_tbl[7] = '{10'd1,    10'd0,    1'b0, 4'd0};

    alive_before = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
    alive_after  = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1};
    dying_before = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};

    req_x = idle_x; req_y = idle_y;
    x_pos = 10'd10; y_pos = 10'd5;

    @(negedge clk_vga);
    check("reset rom_en", rom_en, 1'b0);
    check("reset rgb", rgb, 12'h0);
    check("reset alpha", alpha, 1'b0);
    check("reset alive", alive, 1'b0);
    check("reset done", done, 1'b0);
    check("reset frame", rom_frame, 3'd0);
    check("reset addr", rom_addr, 4'd0);
    @(posedge clk_vga); #1 rst = 1'b0;

    // destroy is ignored while dead; a dead sprite never enables the ROM
    idle(1);
    pulse(1'b0, 1'b1);
    idle(1);
    check("dead ignores destroy", alive, 1'b0);
    cyc(10'd0, 10'd0, 1'b1, 1'b0, 4'd0, 3'd0);
    idle(1);

    // reset in the middle of an active scan
    pulse(1'b1, 1'b0);
    idle(1);
    check("spawn alive", alive, 1'b1);
    tick();
    cyc(10'd10, 10'd5, 1'b1, 1'b1, 4'd0, 3'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst rom_en", rom_en, 1'b0);
    check("midrst alive", alive, 1'b0);
    check("midrst rgb", rgb, 12'h0);
    check("midrst alpha", alpha, 1'b0);
    check("midrst frame", rom_frame, 3'd0);
    check("midrst addr", rom_addr, 4'd0);
    pend_vld = 1'b0;
    @(posedge clk_vga); #1 rst = 1'b0;
    cyc(10'd10, 10'd5, 1'b1, 1'b0, 4'd0, 3'd0);
    idle(1);

    pulse(1'b1, 1'b0);
    idle(1);
    check("respawn alive", alive, 1'b1);

    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("alive frame seq", rom_frame, alive_before[k]);
      tick();
      if (k == 0) begin
        for (int i = 0; i < 18; i++)
          cyc(main_tbl[i].x, main_tbl[i].y, 1'b1, main_tbl[i].en, main_tbl[i].addr, alive_after[k]);
      end else if (k == 1) begin
        x_pos = 10'd20;
        cyc(10'd10, 10'd5, 1'b1, 1'b1, 4'd0, alive_after[k]);
        cyc(10'd20, 10'd5, 1'b1, 1'b0, 4'd0, alive_after[k]);
      end else if (k == 2) begin
        cyc(10'd20, 10'd5, 1'b1, 1'b1, 4'd0, alive_after[k]);
        cyc(10'd10, 10'd5, 1'b1, 1'b0, 4'd0, alive_after[k]);
        x_pos = 10'd10;
      end
    end

    // destroy and spawn together: destroy wins
    idle(1);
    pulse(1'b1, 1'b1);
    idle(1);
    check("destroy wins alive", alive, 1'b0);
    check("dying first frame", rom_frame, 3'd2);
    pulse(1'b1, 1'b0);
    idle(1);
    check("dying ignores spawn", alive, 1'b0);

    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("dying frame seq", rom_frame, dying_before[k]);
      check("no early done", done_cnt, 0);
      tick();
    end
    idle(1);
    check("done pulses once", done_cnt, 1);
    check("dead after done alive", alive, 1'b0);
    check("dead after done frame", rom_frame, 3'd0);
    cyc(10'd10, 10'd5, 1'b1, 1'b0, 4'd0, 3'd0);
    idle(1);

    // sprite hanging off the bottom-right corner must not wrap to 0
    idle_x = 10'd0; idle_y = 10'd0;
    x_pos = 10'd1022; y_pos = 10'd1023;
    idle(1);
    pulse(1'b1, 1'b0);
    tick();
    for (int i = 0; i < 8; i++)
      cyc(edge_tbl[i].x, edge_tbl[i].y, 1'b1, edge_tbl[i].en, edge_tbl[i].addr, 3'd0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_anim_render.md
Name: sprite_anim_render

Overview:
- Generic parametrised sprite renderer for any on-screen object (player craft, enemies, bullets).
- Steps a ROM pixel address as the VGA scan crosses the sprite window.
- Runs a life-cycle state machine (DEAD / ALIVE / DYING) that cycles normal animation frames, then plays a one-shot destroy sequence.
- Emits gray-expanded RGB plus alpha to the layer mixer; the frame ROM is instantiated outside the block.

Parameters:
- H_BITS, 10, width of horizontal pixel address and x position
- V_BITS, 10, width of vertical pixel address and y position
- X_SIZE, 32, sprite width in pixels
- Y_SIZE, 32, sprite height in pixels
- GRAY_BITS, 4, gray depth per pixel; RGB = 3*GRAY_BITS
- NUM_FRAMES, 2, normal animation frames (>=1)
- DESTROY_FRAMES, 3, destroy animation frames (>=1)
- FRAME_HOLD, 8, video frames each image is held (>=1)

Ports:
- clk_vga  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- v_sync_i  in  1  vertical sync, active-low
- req_x_addr_i  in  H_BITS  scan x of requested pixel
- req_y_addr_i  in  V_BITS  scan y of requested pixel
- x_pos_i  in  H_BITS  sprite top-left x
- y_pos_i  in  V_BITS  sprite top-left y
- spawn_i  in  1  pulse: DEAD -> ALIVE
- destroy_i  in  1  pulse: ALIVE -> DYING
- rom_en_o  out  1  ROM read enable
- rom_addr_o  out  clog2(X_SIZE*Y_SIZE)  pixel index within frame
- rom_frame_o  out  clog2(NUM_FRAMES+DESTROY_FRAMES)  frame select
- rom_data_i  in  1+GRAY_BITS  {alpha, gray}, 1-cycle read latency
- vga_rgb_o  out  3*GRAY_BITS  {3{gray}} when visible, else 0
- vga_alpha_o  out  1  pixel opaque
- alive_o  out  1  state is ALIVE
- done_o  out  1  1-cycle pulse when destroy sequence ends

Behaviour:
- Reset (asynchronous): state DEAD; img_idx, hold_cnt, pix_cnt = 0; latched position 0; vis_d = 0; all outputs 0.
- frame_tick: 1-cycle pulse on the cycle after v_sync_i is sampled 1 then 0, detected with a registered previous value.
- On frame_tick:
  - latch x_pos_i/y_pos_i into x_lat/y_lat; the sprite never moves mid-frame.
  - clear pix_cnt.
- in_area = (state != DEAD) && req_x >= x_lat && req_x < x_lat+X_SIZE && req_y >= y_lat && req_y < y_lat+Y_SIZE.
  - Sums computed one bit wider, so windows touching the screen edge do not wrap.
- rom_en_o = in_area; rom_addr_o = pix_cnt (combinational).
- pix_cnt increments on each cycle in_area is high. It saturates at X_SIZE*Y_SIZE-1 and never wraps within a frame.
- vis_d <= in_area, registered.
- Output gating, same cycle as rom_data_i:
  - vga_alpha_o = vis_d & rom_data_i[GRAY_BITS].
  - vga_rgb_o = vis_d ? {3{gray}} : 0.
- Latency: pixel requested at cycle n is output at cycle n+1.
- rom_frame_o = img_idx in ALIVE; NUM_FRAMES+img_idx in DYING; 0 in DEAD.
- DEAD:
  - invisible; destroy_i ignored.
  - spawn_i -> ALIVE, img_idx=0, hold_cnt=0.
- ALIVE:
  - on frame_tick, hold_cnt++. At FRAME_HOLD-1 it clears and img_idx advances modulo NUM_FRAMES.
  - destroy_i -> DYING, img_idx=0, hold_cnt=0.
  - destroy_i wins over a simultaneous spawn_i and frame_tick; spawn_i is ignored.
- DYING:
  - spawn_i and destroy_i are ignored.
  - hold cadence is the same as ALIVE.
  - On the hold expiry of img_idx=DESTROY_FRAMES-1: -> DEAD, img_idx=0, done_o=1 for one cycle.
- A state change takes effect at the next clock. A pixel already in flight (vis_d) still completes with the previous rom_frame_o's data.
- alive_o = (state==ALIVE), registered with the state.

Test Plan:
- Params X_SIZE=4, Y_SIZE=3, NUM_FRAMES=2, DESTROY_FRAMES=3, FRAME_HOLD=2. Reset mid-run -> all outputs 0, state DEAD, no rom_en_o during scan.
- spawn_i; frame_tick with pos (10,5); scan rows 5..7, x 10..13 -> rom_addr_o 0..11 in order, rom_en_o high exactly 12 cycles. vga_rgb_o = {3{gray}} one cycle after each request; alpha follows ROM bit.
- ALIVE over 6 frame_ticks -> rom_frame_o sequence 0,0,1,1,0,0 (wrap).
- destroy_i and spawn_i in the same cycle -> DYING; rom_frame_o 2,2,3,3,4,4 over ticks. done_o pulses once after the 6th tick; then DEAD, outputs 0, alive_o=0.
- Change x_pos_i 10 -> 20 mid-frame -> window stays at x 10..13 until the next frame_tick.
- Position (HMAX-2, VMAX-1) with 10-bit addresses -> no wrap-around; only in-screen pixels are enabled, and pix_cnt never exceeds 11.
